// File: rtl/user_clock_pkg.sv
// rtl/user_clock_pkg.sv - shared mode encodings and step FSM state type for user_clock and its input conditioner
package user_clock_pkg;

   localparam logic [1:0] MODE_SLOW       = 2'b00;
   localparam logic [1:0] MODE_SINGLESTEP = 2'b01;
   localparam logic [1:0] MODE_FAST       = 2'b10;
   localparam logic [1:0] MODE_FASTEST    = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT,
      REPEAT
   } step_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - plain two-flop synchroniser, cleared by synchronous reset
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/step_input_conditioner.sv
// rtl/step_input_conditioner.sv - synchronise and debounce step button and mode switches for user_clock
// Optional auto-repeat of the step button while held: STEP_AUTO_REPEAT_EN.
module step_input_conditioner
   import user_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
`ifdef STEP_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_HALF     = 2500000
`endif
) (
   input  logic        source_clock,
   input  logic        reset,
   input  logic        step_raw,
   input  logic [1:0]  mode_raw,
   output logic        step,
   output logic [1:0]  mode,
   output logic        step_pulse,
   output logic [15:0] press_count
);

   localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
`ifdef STEP_AUTO_REPEAT_EN
   localparam logic [31:0] REP_LAST  = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] HALF_LAST = 32'(REPEAT_HALF - 1);
`endif

   logic        s_step;
   logic [1:0]  s_mode;
   logic [1:0]  s_mode_q;
   logic [31:0] mcnt;

   step_state_t state, state_n;
   logic [31:0] cnt, cnt_n;
   logic        step_n;
   logic        rise;
   logic [15:0] press_cnt;

   sync_2ff #(.WIDTH(1)) u_sync_step (
      .clk   (source_clock),
      .reset (reset),
      .d     (step_raw),
      .q     (s_step)
   );

   sync_2ff #(.WIDTH(2)) u_sync_mode (
      .clk   (source_clock),
      .reset (reset),
      .d     (mode_raw),
      .q     (s_mode)
   );

   assign press_count = press_cnt;

   always_ff @(posedge source_clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         step       <= 1'b0;
         step_pulse <= 1'b0;
         press_cnt  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         step       <= step_n;
         step_pulse <= rise;
         if (rise)
            press_cnt <= press_cnt + 16'd1;
      end
   end

   // cnt is shared by all states and restarts from zero on every transition.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      step_n  = step;
      rise    = 1'b0;
      case (state)
         IDLE: begin
            step_n = 1'b0;
            if (s_step) begin
               state_n = PRESS_WAIT;
               cnt_n   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s_step) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n = PRESSED;
               cnt_n   = '0;
               step_n  = 1'b1;
               rise    = 1'b1;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         PRESSED: begin
            step_n = 1'b1;
            if (!s_step) begin
               state_n = RELEASE_WAIT;
               cnt_n   = '0;
            end
`ifdef STEP_AUTO_REPEAT_EN
            else if (cnt == REP_LAST) begin
               state_n = REPEAT;
               cnt_n   = '0;
               step_n  = 1'b0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
`endif
         end
         RELEASE_WAIT: begin
            if (s_step) begin
               state_n = PRESSED;
               cnt_n   = '0;
               step_n  = 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
               // Step may be low here if the release began during a repeat low phase.
               rise    = !step;
`endif
            end else if (cnt == DEB_LAST) begin
               state_n = IDLE;
               cnt_n   = '0;
               step_n  = 1'b0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
`ifdef STEP_AUTO_REPEAT_EN
         REPEAT: begin
            if (!s_step) begin
               state_n = RELEASE_WAIT;
               cnt_n   = '0;
            end else if (cnt == HALF_LAST) begin
               cnt_n  = '0;
               step_n = !step;
               rise   = !step;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            step_n  = 1'b0;
         end
      endcase
   end

   // s_mode_q detects a fresh change of the synchronised switches so the count restarts.
   always_ff @(posedge source_clock) begin
      if (reset) begin
         mode     <= MODE_SINGLESTEP;
         mcnt     <= '0;
         s_mode_q <= '0;
      end else begin
         s_mode_q <= s_mode;
         if ((s_mode != s_mode_q) || (s_mode == mode)) begin
            mcnt <= '0;
         end else if (mcnt == DEB_LAST) begin
            mode <= s_mode;
            mcnt <= '0;
         end else begin
            mcnt <= mcnt + 32'd1;
         end
      end
   end

endmodule
